// File: rtl/logic_pkg.sv
// Shared helpers for the logic_basic_* stream blocks.
package logic_pkg;

  // Counter width for a count range of n values; never narrower than one bit.
  function automatic int logic_clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/logic_basic_downsizer.sv
// Width downsizer: one WIDTH*RATIO-bit rx word out as RATIO WIDTH-bit tx beats, LS slice first.
// tx outputs come straight from registers; rx_tready depends only on state and tx_tready.
module logic_basic_downsizer
  import logic_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int RATIO = 2
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic                   rx_tvalid,
  input  logic [WIDTH*RATIO-1:0] rx_tdata,
  output logic                   rx_tready,
  input  logic                   tx_tready,
  output logic                   tx_tvalid,
  output logic [WIDTH-1:0]       tx_tdata,
  output logic                   tx_tlast
);

  localparam int            CW     = logic_clog2_min1(RATIO);
  localparam logic [CW-1:0] C_LAST = CW'(RATIO - 1);

  logic [RATIO-1:0][WIDTH-1:0] word_q;
  logic [CW-1:0]               cnt_q;
  logic                        vld_q;
  logic                        last_beat;
  logic                        rx_hs;
  logic                        tx_hs;

  assign last_beat = (cnt_q == C_LAST);
  assign rx_tready = !vld_q || (tx_tready && last_beat);
  assign rx_hs     = rx_tvalid && rx_tready;
  assign tx_hs     = vld_q && tx_tready;

  // A new word overrides the counter update, so last beat + accept has no bubble.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      word_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
    end else if (rx_hs) begin
      word_q <= rx_tdata;
      cnt_q  <= '0;
      vld_q  <= 1'b1;
    end else if (tx_hs) begin
      if (last_beat) begin
        cnt_q <= '0;
        vld_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  generate
    if (RATIO == 1) begin : g_pass
      assign tx_tdata = word_q[0];
    end else begin : g_mux
      assign tx_tdata = word_q[cnt_q];
    end
  endgenerate

  assign tx_tvalid = vld_q;
  assign tx_tlast  = vld_q && last_beat;

endmodule

// File: tb/tb_logic_basic_downsizer.sv
// Bench for logic_basic_downsizer: 8x4 instance under a queue scoreboard, 16x1 instance directed.
module tb_logic_basic_downsizer;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int BW = 16;

  logic           aclk = 1'b0;
  logic           areset_n;
  logic           rx_tvalid, rx_tready, tx_tready, tx_tvalid, tx_tlast;
  logic [W*R-1:0] rx_tdata;
  logic [W-1:0]   tx_tdata;
  logic           b_rx_tvalid, b_rx_tready, b_tx_tready, b_tx_tvalid, b_tx_tlast;
  logic [BW-1:0]  b_rx_tdata, b_tx_tdata;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  beat_t        expq[$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           rdy_mode = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;

  logic_basic_downsizer #(.WIDTH(W), .RATIO(R)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata), .rx_tready(rx_tready),
    .tx_tready(tx_tready), .tx_tvalid(tx_tvalid), .tx_tdata(tx_tdata), .tx_tlast(tx_tlast)
  );

  logic_basic_downsizer #(.WIDTH(BW), .RATIO(1)) dut_b (
    .aclk(aclk), .areset_n(areset_n),
    .rx_tvalid(b_rx_tvalid), .rx_tdata(b_rx_tdata), .rx_tready(b_rx_tready),
    .tx_tready(b_tx_tready), .tx_tvalid(b_tx_tvalid), .tx_tdata(b_tx_tdata), .tx_tlast(b_tx_tlast)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  // Offer a word and wait for acceptance; expected beats are queued as the word is taken.
  task automatic send_word(input logic [W*R-1:0] w);
    int n = 0;
    rx_tvalid = 1'b1;
    rx_tdata  = w;
    @(negedge aclk);
    while (!rx_tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!rx_tready) begin
      chk("rx_accept_timeout", rx_tready, 1);
      rx_tvalid = 1'b0;
      return;
    end
    for (int i = 0; i < R; i++)
      expq.push_back(beat_t'{d: W'(w >> (W * i)), l: (i == R - 1)});
    @(posedge aclk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    chk("drain_empty", expq.size(), 0);
    @(posedge aclk); #1;
  endtask

  // tx_tready driver: 0 = always ready, 1 = random 50%, 2 = stalled
  initial begin
    tx_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (rdy_mode)
        0:       tx_tready = 1'b1;
        1:       tx_tready = 1'($urandom_range(0, 1));
        default: tx_tready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expected beats on each tx handshake and checks stall stability.
  initial begin
    beat_t e;
    forever begin
      @(negedge aclk);
      if (!areset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", tx_tvalid, 1);
          chk("hold_data", tx_tdata, prev_data);
          chk("hold_last", tx_tlast, prev_last);
        end
        if (tx_tvalid && tx_tready) begin
          if (expq.size() == 0) chk("unexpected_beat", tx_tvalid, 0);
          else begin
            e = expq.pop_front();
            chk("beat_data", tx_tdata, e.d);
            chk("beat_last", tx_tlast, e.l);
          end
        end
        prev_stall = tx_tvalid && !tx_tready;
        prev_data  = tx_tdata;
        prev_last  = tx_tlast;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    areset_n    = 1'b0;
    rx_tvalid   = 1'b1;
    rx_tdata    = 32'hCAFE_F00D;
    b_rx_tvalid = 1'b1;
    b_rx_tdata  = 16'hA5A5;
    b_tx_tready = 1'b0;

    // reset held with rx_tvalid high: nothing captured
    repeat (3) begin
      @(negedge aclk);
      chk("rst_tvalid", tx_tvalid, 0);
      chk("rst_tdata", tx_tdata, 0);
      chk("rst_tlast", tx_tlast, 0);
      chk("rst_rx_ready", rx_tready, 1);
      chk("rst_b_tvalid", b_tx_tvalid, 0);
      chk("rst_b_tdata", b_tx_tdata, 0);
    end
    @(posedge aclk); #1;
    areset_n    = 1'b1;
    rx_tvalid   = 1'b0;
    b_rx_tvalid = 1'b0;
    @(negedge aclk);
    chk("post_rst_idle", tx_tvalid, 0);
    @(posedge aclk); #1;

    // single word, first beat one cycle after accept, tlast on 4th only
    send_word(32'hDDCCBBAA);
    rx_tvalid = 1'b0;
    for (int i = 0; i < R; i++) begin
      @(negedge aclk);
      chk("t2_valid", tx_tvalid, 1);
      chk("t2_last", tx_tlast, (i == R - 1));
    end
    drain();

    // back-to-back words: eight beats, no bubble, rx_tready only with tlast
    fork
      begin
        send_word(32'h44332211);
        send_word(32'h88776655);
        rx_tvalid = 1'b0;
      end
      begin
        @(negedge aclk);
        for (int i = 0; i < 2 * R; i++) begin
          @(negedge aclk);
          chk("t3_no_bubble", tx_tvalid, 1);
          chk("t3_rx_ready", rx_tready, tx_tlast);
        end
      end
    join
    drain();

    // random backpressure and random idle gaps
    rdy_mode = 1;
    for (int k = 0; k < 1000; k++) begin
      send_word($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rx_tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge aclk);
        #1;
      end
    end
    rx_tvalid = 1'b0;
    rdy_mode  = 0;
    drain();

    // reset after the 2nd beat discards the rest of the word
    send_word(32'hDDCCBBAA);
    rx_tvalid = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    @(posedge aclk); #1;
    areset_n = 1'b0;
    expq.delete();
    @(posedge aclk); #1;
    areset_n = 1'b1;
    @(negedge aclk);
    chk("t5_tvalid_after_rst", tx_tvalid, 0);
    chk("t5_tdata_after_rst", tx_tdata, 0);
    @(posedge aclk); #1;
    send_word(32'h01020304);
    rx_tvalid = 1'b0;
    drain();

    // RATIO=1 pipeline register under backpressure
    b_rx_tdata  = 16'hBEEF;
    b_rx_tvalid = 1'b1;
    @(negedge aclk);
    chk("t6_rx_ready_idle", b_rx_tready, 1);
    @(posedge aclk); #1;
    b_rx_tvalid = 1'b0;
    b_rx_tdata  = 16'h1234;
    repeat (3) begin
      @(negedge aclk);
      chk("t6_valid", b_tx_tvalid, 1);
      chk("t6_data", b_tx_tdata, 16'hBEEF);
      chk("t6_last", b_tx_tlast, 1);
      chk("t6_rx_ready_stalled", b_rx_tready, 0);
    end
    @(posedge aclk); #1;
    b_tx_tready = 1'b1;
    @(negedge aclk);
    chk("t6_rx_ready_release", b_rx_tready, 1);
    chk("t6_data_release", b_tx_tdata, 16'hBEEF);
    @(posedge aclk); #1;
    b_tx_tready = 1'b0;
    @(negedge aclk);
    chk("t6_empty_after_hs", b_tx_tvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
